// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction register, fetches over a
// req/ack handshake and presents each instruction for exactly one EXEC cycle.
module fetch_unit #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  input  logic               jmp_sel,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] ir_next;
  logic [PC_W-1:0]    pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= PC_W'(RESET_PC);
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        // run is not consulted here: a started fetch always completes
        if (mem_ack) begin
          ir_next    = mem_rdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        pc_next    = jmp_sel ? PC_W'(ir[3:0]) : pc + PC_W'(1);
        state_next = run ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so they stay glitch-free;
  // the zero opcode outside EXEC is what keeps the control unit inert.
  assign mem_req     = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign mem_addr    = pc;
  assign opcode      = (state == EXEC) ? ir[INSTR_W-1 -: 4] : 4'b0000;
  assign operand     = ir[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// programs, wait states and jumps checked against a transaction-level model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       jmp_sel;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       instr_valid;
  logic [3:0] pc;

  logic [7:0] rom [16];
  logic [7:0] junk;
  logic [3:0] mpc;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_unit #(.PC_W(4), .INSTR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .jmp_sel(jmp_sel), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  // Data is only meaningful alongside ack; otherwise present garbage.
  assign mem_rdata = mem_ack ? rom[mem_addr] : junk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered while in FETCH at model pc; completes one instruction.
  task automatic run_instr(input int unsigned waits, input bit jmp, input bit drop);
    logic [7:0] ins;
    ins = rom[mpc];
    for (int unsigned i = 0; i <= waits; i++) begin
      check("fetch_req", mem_req, 1);
      check("fetch_addr", mem_addr, mpc);
      check("fetch_valid", instr_valid, 0);
      check("fetch_opcode", opcode, 0);
      junk    = 8'($urandom);
      mem_ack = (i == waits);
      if (drop) run = 1'b0;
      step();
    end
    mem_ack = 1'($urandom_range(0, 1));
    check("exec_valid", instr_valid, 1);
    check("exec_req", mem_req, 0);
    check("exec_opcode", opcode, ins[7:4]);
    check("exec_operand", operand, ins[3:0]);
    check("exec_pc", pc, mpc);
    jmp_sel = jmp;
    step();
    jmp_sel = 1'b0;
    mem_ack = 1'b0;
    mpc = jmp ? ins[3:0] : 4'((mpc + 1) % 16);
    check("next_pc", pc, mpc);
    check("after_exec_valid", instr_valid, 0);
    if (run) begin
      check("next_req", mem_req, 1);
      check("next_addr", mem_addr, mpc);
    end else begin
      check("idle_req", mem_req, 0);
      check("idle_opcode", opcode, 0);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mem_ack = 1'b1; jmp_sel = 1'b0; junk = 8'h00;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h51; rom[1] = 8'h62; rom[2] = 8'h73; rom[3] = 8'h84;
    rom[4] = 8'hA5; rom[5] = 8'h39; rom[9] = 8'h4A; rom[10] = 8'h0F; rom[15] = 8'h12;
    step();
    step();
    check("rst_req", mem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_valid", instr_valid, 0);
    rst = 1'b0;
    mem_ack = 1'b0;
    step();
    mpc = 4'd0;
    check("start_req", mem_req, 1);
    check("start_addr", mem_addr, 0);

    // Sequential fetch with zero-wait memory
    for (int i = 0; i < 4; i++) run_instr(0, 1'b0, 1'b0);
    // Three wait states at address 4
    run_instr(3, 1'b0, 1'b0);
    // 0x39 jumps to 9, 0x4A falls through to 10, 0x0F jumps to 15
    run_instr(0, 1'b1, 1'b0);
    check("jump_target", mem_addr, 9);
    run_instr(1, 1'b0, 1'b0);
    check("no_jump_addr", mem_addr, 10);
    run_instr(0, 1'b1, 1'b0);
    // pc 15 wraps to 0 and run drops mid-fetch
    run_instr(2, 1'b0, 1'b1);
    check("wrap_pc", pc, 0);
    step();
    check("stay_idle_req", mem_req, 0);
    check("stay_idle_pc", pc, 0);

    // Tight loop at 0 (jump to current pc), then jump to 6 for the reset test
    rom[0] = 8'h20;
    run = 1'b1;
    step();
    run_instr(0, 1'b1, 1'b0);
    check("tight_loop", mem_addr, 0);
    rom[0] = 8'h26;
    run_instr(0, 1'b1, 1'b0);
    check("pre_rst_addr", mem_addr, 6);
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", mem_req, 0);
    check("async_rst_pc", pc, 0);
    check("async_rst_valid", instr_valid, 0);
    run = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle", mem_req, 0);
    run = 1'b1;
    step();
    mpc = 4'd0;
    check("post_rst_fetch", mem_req, 1);
    check("post_rst_addr", mem_addr, 0);

    // Randomized programs, wait states, jumps and run drops
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 80; n++) begin
      bit drop;
      drop = ($urandom_range(0, 7) == 0);
      run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), drop);
      if (drop) begin
        int unsigned idle;
        idle = $urandom_range(0, 2);
        for (int unsigned k = 0; k < idle; k++) begin
          mem_ack = 1'($urandom_range(0, 1));
          step();
          check("rand_idle_req", mem_req, 0);
          check("rand_idle_pc", pc, mpc);
        end
        mem_ack = 1'b0;
        run = 1'b1;
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 4-bit CPU. It holds the program counter and the instruction register, and fetches 8-bit instruction words from program memory through a request/acknowledge handshake. It presents the decoded opcode and operand fields to the control unit for exactly one execute cycle per instruction. It advances the PC sequentially, or loads it from the operand field when the control unit's jump select is asserted.

## Interface
Parameters:
- PC_W, 4, program counter / program memory address width
- INSTR_W, 8, instruction word width; [7:4] opcode, [3:0] operand/immediate
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- run  in  1  enables fetching; sampled in IDLE and at end of EXEC
- mem_req  out  1  program memory read request
- mem_addr  out  PC_W  program memory address; equals pc
- mem_rdata  in  INSTR_W  instruction word from program memory
- mem_ack  in  1  memory has valid mem_rdata this cycle
- jmp_sel  in  1  jump taken, from control unit; combinational from current opcode/flags
- opcode  out  4  IR[7:4] during EXEC, else 4'b0000
- operand  out  4  IR[3:0]; held continuously
- instr_valid  out  1  high only in EXEC
- pc  out  PC_W  current program counter

## Operation
- FSM states: IDLE, FETCH, EXEC.
- Reset (async) values:
  - state=IDLE, pc=RESET_PC, IR=0.
  - mem_req=0, instr_valid=0, opcode=0000, operand=0000.
- IDLE:
  - Outputs idle.
  - run=1 → FETCH next cycle.
  - run=0 → stay.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - mem_ack=1 → IR<=mem_rdata on this edge, → EXEC.
  - mem_ack=0 → stay with request held and address stable.
  - Deasserting run does not abort a fetch in progress.
- EXEC (exactly one cycle):
  - instr_valid=1, opcode=IR[7:4].
  - On the exiting edge: jmp_sel=1 → pc<=IR[3:0] zero-extended to PC_W; else pc<=pc+1 mod 2^PC_W (15→0 wraps, no flag).
  - Next state: run=1 → FETCH, else IDLE.
- Opcode 0000 outside EXEC guarantees no register write and no jump while fetching or idle. Downstream needs no extra gating.
- mem_ack outside FETCH is ignored. mem_rdata is sampled only in FETCH with mem_ack.
- Jump to the current pc is legal (tight loop).

## Timing
- mem_req, instr_valid, opcode and mem_addr are registered/state-decoded outputs. They are glitch-free relative to clk.
- Instruction latency: FETCH entered at cycle N with mem_ack tied high gives EXEC at N+1 and the next FETCH at N+2. Steady-state throughput is 1 instruction per 2 cycles.
- Each cycle of mem_ack delay adds one FETCH cycle.
- The new pc is visible on mem_addr the cycle after EXEC.
- jmp_sel must settle within the EXEC cycle. It is a combinational path from opcode through the control unit back into pc next-state.
- Reset asserted mid-FETCH or mid-EXEC: mem_req and instr_valid drop immediately (async) and the pending PC update is lost. After deassertion the block waits in IDLE for run.

## Test plan
- Reset check: rst=1 with run=1 → mem_req=0, pc=0, opcode=0000, instr_valid=0. After release, FETCH is entered on the next edge with mem_addr=0.
- Sequential fetch: ROM returns 0x51, 0x62, 0x73 at addresses 0-2, mem_ack tied 1, jmp_sel=0 → EXEC opcodes 5, 6, 7 with operands 1, 2, 3 on cycles 2, 4, 6. pc goes 1, 2, 3.
- Wait states: mem_ack delayed 3 cycles at address 4 → mem_req stays 1 and mem_addr stays 4 for 4 cycles, followed by a single EXEC.
- Jump: instruction 0x39 with jmp_sel=1 in EXEC → next mem_addr=9. With jmp_sel=0 → next mem_addr=pc+1.
- Wrap and stop: pc=15, no jump → pc=0. run dropped during FETCH → fetch completes, EXEC runs, then IDLE with mem_req=0.
- Async reset mid-FETCH at pc=6 → mem_req drops before the next edge and pc=0.
